mips_avalon_arbiter: RTL and testbench

Two-master, one-slave Avalon-MM arbiter that shares the single `mips_avalon_slave` memory between the CPU instruction-fetch port (master 0) and the data/write-buffer port (master 1). It sits between `mips_cpu_bus` internals and the memory bus. It grants one single-word transfer at a time with round-robin fairness and forwards slave `waitrequest`/`readdata` to the granted master. A sticky protocol-error flag is provided for the testbench.

---
 rtl/mips_avalon_pkg.sv | 10 +
 rtl/mips_avalon_arbiter.sv | 91 +++++++++
 tb/tb_mips_avalon_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_avalon_pkg.sv
// mips_avalon_pkg: shared Avalon widths, arbiter state type and round-robin pick.
package mips_avalon_pkg;
  localparam int AV_ADDR_W = 32;
  localparam int AV_DATA_W = 32;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT0, ARB_GRANT1} arb_state_t;
  // Returns the master index to grant; on a tie the master that did not go last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    return (req0 && req1) ? ~last : req1;
  endfunction
endpackage

// File: rtl/mips_avalon_arbiter.sv
// mips_avalon_arbiter: round-robin two-master to one-slave Avalon-MM arbiter, one word per grant.
module mips_avalon_arbiter import mips_avalon_pkg::*; #(
  parameter int ADDR_W = AV_ADDR_W,
  parameter int DATA_W = AV_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m0_read,
  input  logic                m1_read,
  input  logic                m0_write,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m0_waitrequest,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic                prot_err
);
  arb_state_t state_q, state_d;
  logic last_q, last_d, prot_q, prot_d;
  logic req0, req1, g0, g1, rd, wr, req, other_req;
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign g0 = state_q == ARB_GRANT0;
  assign g1 = state_q == ARB_GRANT1;
  assign rd = g1 ? m1_read : m0_read;
  assign wr = g1 ? m1_write : m0_write;
  assign req = rd | wr;
  assign other_req = g1 ? req0 : req1;
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign prot_err = prot_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    prot_d = prot_q;
    s_address = '0;
    s_byteenable = '0;
    s_writedata = '0;
    s_read = 1'b0;
    s_write = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (!(g0 || g1)) begin
      if (req0 || req1) state_d = rr_pick(req0, req1, last_q) ? ARB_GRANT1 : ARB_GRANT0;
    end else begin
      s_address = g1 ? m1_address : m0_address;
      s_byteenable = g1 ? m1_byteenable : m0_byteenable;
      s_writedata = g1 ? m1_writedata : m0_writedata;
      if (!req) begin
        state_d = ARB_IDLE;
        prot_d = 1'b1;
      end else if (rd && wr) begin
        prot_d = 1'b1;
      end else begin
        s_read = rd;
        s_write = wr;
        m0_waitrequest = g1 | s_waitrequest;
        m1_waitrequest = g0 | s_waitrequest;
        // Hand over directly to a waiting peer so alternating traffic has no bubble.
        if (!s_waitrequest) begin
          last_d = g1;
          state_d = other_req ? (g1 ? ARB_GRANT0 : ARB_GRANT1) : ARB_IDLE;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      last_q <= 1'b1;
      prot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      prot_q <= prot_d;
    end
  end
endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// tb_mips_avalon_arbiter: table-driven and scoreboard bench for the two-master arbiter.
module tb_mips_avalon_arbiter;
  import mips_avalon_pkg::*;
  typedef struct { logic rd; logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] data; } txn_t;
  typedef struct { int m; logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] data; } exp_t;
  typedef struct { int m; logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] data; int waits; int lat; } vec_t;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] m0_address = '0, m1_address = '0, m0_writedata = '0, m1_writedata = '0;
  logic [3:0] m0_byteenable = '0, m1_byteenable = '0;
  logic m0_read = 1'b0, m1_read = 1'b0, m0_write = 1'b0, m1_write = 1'b0;
  logic m0_waitrequest, m1_waitrequest, s_read, s_write, s_waitrequest, prot_err;
  logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata, s_readdata;
  logic [3:0] s_byteenable;
  int checks = 0, passes = 0, wait_n = 0, wcnt = 0, n0 = 0, n1 = 0, lat = 0;
  logic [31:0] last_wa = '0, last_wd = '0, prev_addr = '0;
  logic prev_wait = 1'b0;
  txn_t q0[$], q1[$];
  exp_t sb[$];
  vec_t tbl[5];

  mips_avalon_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m1_address(m1_address),
    .m0_byteenable(m0_byteenable), .m1_byteenable(m1_byteenable),
    .m0_read(m0_read), .m1_read(m1_read), .m0_write(m0_write), .m1_write(m1_write),
    .m0_writedata(m0_writedata), .m1_writedata(m1_writedata),
    .m0_waitrequest(m0_waitrequest), .m1_waitrequest(m1_waitrequest),
    .m0_readdata(m0_readdata), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .prot_err(prot_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Slave model: wait_n stall cycles per access, address-derived read data, last write logged.
  assign s_waitrequest = (s_read | s_write) && (wcnt < wait_n);
  assign s_readdata = mem_word(s_address);
  always @(posedge clk) begin
    wcnt <= ((s_read | s_write) && wcnt < wait_n) ? wcnt + 1 : 0;
    if (s_write && !s_waitrequest) begin
      last_wa <= s_address;
      last_wd <= s_writedata;
    end
  end

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endfunction

  task automatic drive(input int i, input txn_t t);
    if (i == 0) begin
      m0_read = t.rd; m0_write = t.wr; m0_address = t.addr; m0_byteenable = t.be; m0_writedata = t.data;
    end else begin
      m1_read = t.rd; m1_write = t.wr; m1_address = t.addr; m1_byteenable = t.be; m1_writedata = t.data;
    end
  endtask

  task automatic add(input int m, input logic wr, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    txn_t t;
    exp_t e;
    t.rd = !wr; t.wr = wr; t.addr = addr; t.be = be; t.data = data;
    if (m == 0) q0.push_back(t); else q1.push_back(t);
    e.m = m; e.wr = wr; e.addr = addr; e.be = be; e.data = wr ? data : mem_word(addr);
    sb.push_back(e);
  endtask

  task automatic kick();
    if (!(m0_read | m0_write) && q0.size() != 0) drive(0, q0.pop_front());
    if (!(m1_read | m1_write) && q1.size() != 0) drive(1, q1.pop_front());
  endtask

  task automatic step();
    logic d0, d1;
    exp_t e;
    @(negedge clk);
    d0 = (m0_read | m0_write) && !m0_waitrequest;
    d1 = (m1_read | m1_write) && !m1_waitrequest;
    if (prev_wait) chk("addr_stable", s_address, prev_addr);
    if ((s_read | s_write) && s_waitrequest) chk("both_stalled", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd3);
    if (d0) chk("m1_stalled", m1_waitrequest, 1);
    if (d1) chk("m0_stalled", m0_waitrequest, 1);
    if (d0 || d1) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("grant_order", {31'd0, d1}, e.m);
        chk("s_address", s_address, e.addr);
        chk("s_write", s_write, e.wr);
        chk("s_byteenable", s_byteenable, e.be);
        if (e.wr) chk("s_writedata", s_writedata, e.data);
        else chk("readdata", d1 ? m1_readdata : m0_readdata, e.data);
      end
      if (d1) n1++; else n0++;
    end
    prev_wait = (s_read | s_write) && s_waitrequest;
    prev_addr = s_address;
    @(posedge clk); #1;
    if (d0) begin m0_read = 1'b0; m0_write = 1'b0; end
    if (d1) begin m1_read = 1'b0; m1_write = 1'b0; end
    kick();
  endtask

  task automatic run(input int budget, output int n);
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_left", sb.size(), 0);
      sb.delete(); q0.delete(); q1.delete();
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_m0_wait", m0_waitrequest, 1);
    chk("idle_m1_wait", m1_waitrequest, 1);
    chk("idle_s_strobes", {30'd0, s_read, s_write}, 0);
    chk("idle_s_address", s_address, 0);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    tbl[0] = '{0, 1'b0, 32'hBFC00000, 4'hF, 32'h0, 0, 2};
    tbl[1] = '{1, 1'b0, 32'h00002000, 4'hF, 32'h0, 0, 2};
    tbl[2] = '{0, 1'b1, 32'h00003000, 4'h3, 32'h12345678, 1, 3};
    tbl[3] = '{1, 1'b1, 32'h00004000, 4'hC, 32'hCAFEF00D, 3, 5};
    tbl[4] = '{0, 1'b0, 32'h00005004, 4'hF, 32'h0, 2, 4};
    m0_read = 1'b1;
    m0_address = 32'hBFC00000;
    repeat (2) @(negedge clk);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_s_read", s_read, 0);
    chk("rst_s_address", s_address, 0);
    chk("rst_prot_err", prot_err, 0);
    m0_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_n = tbl[i].waits;
      add(tbl[i].m, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].data);
      kick();
      run(20, lat);
      chk("vec_latency", lat, tbl[i].lat);
      idle_check();
    end
    apply_reset();
    wait_n = 0;
    add(0, 1'b0, 32'hBFC00008, 4'hF, 32'h0);
    add(1, 1'b1, 32'h00001000, 4'hF, 32'hDEADBEEF);
    kick();
    run(10, lat);
    chk("tie_latency", lat, 3);
    chk("tie_mem_addr", last_wa, 32'h00001000);
    chk("tie_mem_data", last_wd, 32'hDEADBEEF);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 10; i++) begin
      add(0, 1'b0, 32'h100 + 32'(i * 4), 4'hF, 32'h0);
      add(1, 1'b1, 32'h200 + 32'(i * 4), 4'hF, 32'(i));
    end
    kick();
    run(40, lat);
    chk("fair_cycles", lat, 21);
    chk("fair_n0", n0, 10);
    chk("fair_n1", n1, 10);
    wait_n = 3;
    add(0, 1'b0, 32'h00000100, 4'hF, 32'h0);
    add(1, 1'b1, 32'h00006000, 4'h1, 32'h0000600D);
    kick();
    run(20, lat);
    chk("wait_latency", lat, 9);
    chk("prot_clean", prot_err, 0);
    wait_n = 5;
    m1_address = 32'h7000; m1_byteenable = 4'hF; m1_writedata = 32'h1; m1_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_s_write", s_write, 1);
    chk("abort_m1_wait", m1_waitrequest, 1);
    @(posedge clk); #1;
    m1_write = 1'b0;
    @(negedge clk);
    chk("abort_prot_pre", prot_err, 0);
    chk("abort_strobe_off", s_write, 0);
    @(negedge clk);
    chk("abort_prot_err", prot_err, 1);
    chk("abort_idle_addr", s_address, 0);
    @(posedge clk); #1;
    apply_reset();
    wait_n = 0;
    m0_address = 32'h200; m0_byteenable = 4'hF; m0_read = 1'b1; m0_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ill_strobes", {30'd0, s_read, s_write}, 0);
    chk("ill_m0_wait", m0_waitrequest, 1);
    chk("ill_prot_pre", prot_err, 0);
    @(negedge clk);
    chk("ill_prot_err", prot_err, 1);
    chk("ill_hold_grant", s_address, 32'h200);
    chk("ill_strobes2", {30'd0, s_read, s_write}, 0);
    @(posedge clk); #1;
    m0_write = 1'b0;
    @(negedge clk);
    chk("ill_fix_read", s_read, 1);
    chk("ill_fix_wait", m0_waitrequest, 0);
    chk("ill_fix_data", m0_readdata, mem_word(32'h200));
    @(posedge clk); #1;
    m0_read = 1'b0;
    wait_n = 5;
    m1_address = 32'h8000; m1_writedata = 32'h5; m1_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_s_write", s_write, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_s_write", s_write, 0);
    chk("mid_rst_m1_wait", m1_waitrequest, 1);
    chk("mid_rst_s_addr", s_address, 0);
    m1_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_prot", prot_err, 0);
    chk("post_rst_strobes", {30'd0, s_read, s_write}, 0);
    chk("post_rst_waits", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd3);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
